// File: rtl/dma_ctl_pkg.sv
// Shared definitions for the CI-programmed DMA transfer controller:
// FSM state encoding, CI register map and operand field positions.
package dma_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQUEST  = 3'd1,
    ST_BEGIN    = 3'd2,
    ST_TRANSFER = 3'd3,
    ST_ERROR    = 3'd4
  } dma_state_e;

  localparam logic [2:0] REG_BUS_ADDR = 3'd0;
  localparam logic [2:0] REG_LOC_ADDR = 3'd1;
  localparam logic [2:0] REG_BLOCK    = 3'd2;
  localparam logic [2:0] REG_BURST    = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_COUNT    = 3'd5;

  localparam int SEL_MSB = 12;
  localparam int SEL_LSB = 10;
  localparam int WE_BIT  = 9;

  // Beats in the next burst: a full burst, or whatever is left of the block.
  function automatic logic [9:0] min_beats(input logic [9:0] burst_len,
                                           input logic [9:0] remaining);
    return (burst_len < remaining) ? burst_len : remaining;
  endfunction

endpackage

// File: rtl/dma_ctl_regs.sv
// CI decode and configuration register file of the DMA controller.
// Produces the registered data_valid/result pair and a go strobe that
// is valid in the same cycle as the accepted control-register write.
module dma_ctl_regs
  import dma_ctl_pkg::*;
#(
  parameter logic [7:0] CustomId = 8'd12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  ci_n_i,
  input  logic [31:0] value_a_i,
  input  logic [31:0] value_b_i,
  input  logic [1:0]  status_i,
  input  logic [31:0] count_i,
  output logic [31:0] result_o,
  output logic        data_valid_o,
  output logic        go_o,
  output logic [9:0]  block_size_o,
  output logic [7:0]  burst_size_o
);

  logic        accept_s;
  logic        we_s;
  logic [2:0]  sel_s;
  logic [31:0] rd_s;
  logic        unused_s;

  logic [31:0] bus_addr_q;
  logic [31:0] loc_addr_q;
  logic [9:0]  block_q;
  logic [7:0]  burst_q;
  logic [31:0] result_q;
  logic        dv_q;

  assign accept_s = start_i && (ci_n_i == CustomId);
  assign sel_s    = value_a_i[SEL_MSB:SEL_LSB];
  assign we_s     = value_a_i[WE_BIT];
  assign go_o     = accept_s && we_s && (sel_s == REG_CTRL) && value_b_i[0];
  assign unused_s = ^{value_a_i[31:13], value_a_i[8:0]};

  // Read multiplexer over pre-edge register contents.
  always_comb begin
    rd_s = 32'd0;
    case (sel_s)
      REG_BUS_ADDR: rd_s = bus_addr_q;
      REG_LOC_ADDR: rd_s = loc_addr_q;
      REG_BLOCK:    rd_s = {22'd0, block_q};
      REG_BURST:    rd_s = {24'd0, burst_q};
      REG_CTRL:     rd_s = {30'd0, status_i};
      REG_COUNT:    rd_s = count_i;
      default:      rd_s = 32'd0;
    endcase
  end

  // Register writes at the accept edge and the one-cycle CI response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_addr_q <= 32'd0;
      loc_addr_q <= 32'd0;
      block_q    <= 10'd0;
      burst_q    <= 8'd0;
      result_q   <= 32'd0;
      dv_q       <= 1'b0;
    end else begin
      dv_q     <= accept_s;
      result_q <= accept_s ? rd_s : 32'd0;
      if (accept_s && we_s) begin
        case (sel_s)
          REG_BUS_ADDR: bus_addr_q <= value_b_i;
          REG_LOC_ADDR: loc_addr_q <= value_b_i;
          REG_BLOCK:    block_q    <= value_b_i[9:0];
          REG_BURST:    burst_q    <= value_b_i[7:0];
          default:      ;
        endcase
      end
    end
  end

  assign result_o     = result_q;
  assign data_valid_o = dv_q;
  assign block_size_o = block_q;
  assign burst_size_o = burst_q;

endmodule

// File: rtl/dma_ctl_ci.sv
// CI-programmed DMA transfer controller: sequences request/grant/begin/
// beat/end for a block moved as a series of bursts.
// Optional build macro DMA_TRANSFER_COUNT_EN adds a readable beat counter
// (register 5); without it register 5 reads zero.
module dma_ctl_ci
  import dma_ctl_pkg::*;
#(
  parameter logic [7:0] customId = 8'd12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic [31:0] result,
  output logic        data_valid,
  output logic        bus_request,
  input  logic        bus_aquire,
  output logic        begin_transaction,
  input  logic        slave_busy,
  input  logic        in_valid,
  input  logic        end_transaction,
  input  logic        bus_error
);

  logic        go_s;
  logic [9:0]  block_s;
  logic [7:0]  burst_s;
  logic [31:0] count_s;

  dma_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic [9:0]  remaining_q, remaining_d;
  logic [9:0]  beats_q, beats_d;
  logic [9:0]  burst_len_q, burst_len_d;
  logic        bus_request_q, bus_request_d;
  logic        begin_q, begin_d;

  dma_ctl_regs #(.CustomId(customId)) u_regs (
    .clk_i        (clock),
    .rst_ni       (reset),
    .start_i      (start),
    .ci_n_i       (ciN),
    .value_a_i    (valueA),
    .value_b_i    (valueB),
    .status_i     ({error_q, busy_q}),
    .count_i      (count_s),
    .result_o     (result),
    .data_valid_o (data_valid),
    .go_o         (go_s),
    .block_size_o (block_s),
    .burst_size_o (burst_s)
  );

  // Next-state, counters and output intent of the bus handshake FSM.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    error_d     = error_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    burst_len_d = burst_len_q;
    begin_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          error_d = 1'b0;
          if (block_s != 10'd0) begin
            busy_d      = 1'b1;
            remaining_d = block_s;
            burst_len_d = {2'b00, burst_s} + 10'd1;
            state_d     = ST_REQUEST;
          end else begin
            busy_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        if (bus_error) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else if (bus_aquire && bus_request_q) begin
          state_d = ST_BEGIN;
        end else begin
          state_d = ST_REQUEST;
        end
      end
      ST_BEGIN: begin
        if (bus_error) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else if (!slave_busy) begin
          begin_d = 1'b1;
          beats_d = min_beats(burst_len_q, remaining_q);
          state_d = ST_TRANSFER;
        end else begin
          state_d = ST_BEGIN;
        end
      end
      ST_TRANSFER: begin
        if (bus_error) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          if (in_valid) begin
            beats_d     = beats_q - 10'd1;
            remaining_d = remaining_q - 10'd1;
          end else begin
            beats_d     = beats_q;
          end
          if ((beats_d == 10'd0) || end_transaction) begin
            if (remaining_d == 10'd0) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_REQUEST;
            end
          end else begin
            state_d = ST_TRANSFER;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Re-entering REQUEST straight from a burst holds the request low for
    // one cycle so the arbiter sees a release between bursts.
    bus_request_d = (state_d == ST_BEGIN) || (state_d == ST_TRANSFER) ||
                    ((state_d == ST_REQUEST) && (state_q != ST_TRANSFER));
  end

  // FSM state, transfer bookkeeping and registered bus outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      remaining_q   <= 10'd0;
      beats_q       <= 10'd0;
      burst_len_q   <= 10'd0;
      bus_request_q <= 1'b0;
      begin_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      remaining_q   <= remaining_d;
      beats_q       <= beats_d;
      burst_len_q   <= burst_len_d;
      bus_request_q <= bus_request_d;
      begin_q       <= begin_d;
    end
  end

`ifdef DMA_TRANSFER_COUNT_EN
  logic [31:0] count_q, count_d;

  // Beats completed since the last accepted go; holds after completion.
  always_comb begin
    count_d = count_q;
    if ((state_q == ST_IDLE) && go_s) begin
      count_d = 32'd0;
    end else if ((state_q == ST_TRANSFER) && in_valid && !bus_error) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_s = count_q;
`else
  assign count_s = 32'd0;
`endif

  assign bus_request       = bus_request_q;
  assign begin_transaction = begin_q;

endmodule

// File: tb/tb_dma_ctl_ci.sv
module tb_dma_ctl_ci;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [31:0] result;
  logic        data_valid;
  logic        bus_request;
  logic        bus_aquire;
  logic        begin_transaction;
  logic        slave_busy;
  logic        in_valid;
  logic        end_transaction;
  logic        bus_error;

  always #5 clock = ~clock;

  dma_ctl_ci #(.customId(8'd12)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .ciN               (ciN),
    .valueA            (valueA),
    .valueB            (valueB),
    .result            (result),
    .data_valid        (data_valid),
    .bus_request       (bus_request),
    .bus_aquire        (bus_aquire),
    .begin_transaction (begin_transaction),
    .slave_busy        (slave_busy),
    .in_valid          (in_valid),
    .end_transaction   (end_transaction),
    .bus_error         (bus_error)
  );

  int checks = 0;
  int errors = 0;
  int begin_cnt = 0;
  int b0;

  // CI scoreboard: {check-flag, expected result}
  logic [32:0] ci_q[$];
  // Directed-observation scoreboard: name, observed, required
  string dn_q[$];
  int    da_q[$];
  int    de_q[$];

`ifdef DMA_TRANSFER_COUNT_EN
  localparam int CNT_ERR = 2;
  localparam int CNT_FULL = 8;
`else
  localparam int CNT_ERR = 0;
  localparam int CNT_FULL = 0;
`endif

  // Monitor: pops and compares whenever the DUT presents an output
  initial begin
    logic [32:0] e;
    logic        begin_prev;
    string       nm;
    int          a;
    int          x;
    begin_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (data_valid) begin
        if (ci_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data_valid result=%h required=no response", result);
        end else begin
          e = ci_q.pop_front();
          if (e[32]) begin
            checks++;
            if (result !== e[31:0]) begin
              errors++;
              $display("FAIL ci_result got=%h required=%h", result, e[31:0]);
            end
          end
        end
      end
      if (begin_transaction) begin
        begin_cnt++;
        if (begin_prev) begin
          checks++;
          errors++;
          $display("FAIL begin_width got=2+ cycles required=1");
        end
      end
      begin_prev = begin_transaction;
      while (dn_q.size() > 0) begin
        nm = dn_q.pop_front();
        a  = da_q.pop_front();
        x  = de_q.pop_front();
        checks++;
        if (a != x) begin
          errors++;
          $display("FAIL %s got=%0d required=%0d", nm, a, x);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic dchk(input string n, input int a, input int e);
    dn_q.push_back(n);
    da_q.push_back(a);
    de_q.push_back(e);
  endtask

  task automatic ci(input logic [7:0] op, input logic [2:0] sel, input logic we,
                    input logic [31:0] b, input logic chk, input logic [31:0] exp);
    start  = 1'b1;
    ciN    = op;
    valueA = {19'd0, sel, we, 9'd0};
    valueB = b;
    if (op == 8'd12) ci_q.push_back({chk, exp});
    step();
    start  = 1'b0;
    ciN    = 8'd0;
    valueA = 32'd0;
    valueB = 32'd0;
  endtask

  // Slave/arbiter side of one burst
  task automatic serve(input int gd, input int bc, input int nb,
                       input bit et, input bit err, input bit more);
    int w;
    int d;
    w = 0;
    while (!bus_request && w < 40) begin
      step();
      w++;
    end
    dchk("request_seen", int'(bus_request), 1);
    repeat (gd) step();
    bus_aquire = 1'b1;
    step();
    bus_aquire = 1'b0;
    for (int k = 0; k < bc; k++) begin
      slave_busy = 1'b1;
      step();
    end
    slave_busy = 1'b0;
    d = 0;
    while (!begin_transaction && d < 40) begin
      step();
      d++;
    end
    dchk("begin_delay", bc + d, bc + 1);
    for (int k = 0; k < nb; k++) begin
      in_valid        = 1'b1;
      end_transaction = et && (k == nb - 1);
      step();
    end
    in_valid        = 1'b0;
    end_transaction = 1'b0;
    if (err) begin
      bus_error = 1'b1;
      step();
      bus_error = 1'b0;
    end
    dchk("request_drop", int'(bus_request), 0);
    if (more) begin
      step();
      dchk("request_back", int'(bus_request), 1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    bus_aquire = 1'b0; slave_busy = 1'b0; in_valid = 1'b0;
    end_transaction = 1'b0; bus_error = 1'b0;
    step(); step();
    dchk("rst_bus_request", int'(bus_request), 0);
    dchk("rst_begin", int'(begin_transaction), 0);
    dchk("rst_data_valid", int'(data_valid), 0);
    dchk("rst_result", int'(result), 0);
    reset = 1'b1;
    step();

    // reset value of burst register, foreign opcode ignored
    ci(8'd12, 3'd3, 1'b0, 32'd0, 1'b1, 32'd0);
    ci(8'd13, 3'd3, 1'b0, 32'd0, 1'b0, 32'd0);
    step(); step();

    // 8 words, burst length 4: two bursts
    ci(8'd12, 3'd3, 1'b1, 32'd3, 1'b0, 32'd0);
    ci(8'd12, 3'd2, 1'b1, 32'd8, 1'b0, 32'd0);
    ci(8'd12, 3'd3, 1'b0, 32'd0, 1'b1, 32'd3);
    ci(8'd12, 3'd2, 1'b0, 32'd0, 1'b1, 32'd8);
    b0 = begin_cnt;
    ci(8'd12, 3'd4, 1'b1, 32'd1, 1'b0, 32'd0);
    ci(8'd12, 3'd4, 1'b0, 32'd0, 1'b1, 32'd1);
    serve(2, 0, 4, 1'b0, 1'b0, 1'b1);
    serve(2, 0, 4, 1'b0, 1'b0, 1'b0);
    dchk("bursts_8x4", begin_cnt - b0, 2);
    ci(8'd12, 3'd4, 1'b0, 32'd0, 1'b1, 32'd0);

    // 5 words: 4 + 1, slave_busy for 3 cycles in first BEGIN
    ci(8'd12, 3'd2, 1'b1, 32'd5, 1'b0, 32'd0);
    b0 = begin_cnt;
    ci(8'd12, 3'd4, 1'b1, 32'd1, 1'b0, 32'd0);
    serve(2, 3, 4, 1'b0, 1'b0, 1'b1);
    serve(2, 0, 1, 1'b0, 1'b0, 1'b0);
    dchk("bursts_5x4", begin_cnt - b0, 2);
    ci(8'd12, 3'd4, 1'b0, 32'd0, 1'b1, 32'd0);

    // 8 words, early end after 2 beats; write + go while busy ignored
    ci(8'd12, 3'd2, 1'b1, 32'd8, 1'b0, 32'd0);
    b0 = begin_cnt;
    ci(8'd12, 3'd4, 1'b1, 32'd1, 1'b0, 32'd0);
    ci(8'd12, 3'd2, 1'b1, 32'd3, 1'b0, 32'd0);
    ci(8'd12, 3'd4, 1'b1, 32'd1, 1'b0, 32'd0);
    serve(1, 0, 2, 1'b1, 1'b0, 1'b1);
    serve(1, 0, 4, 1'b0, 1'b0, 1'b1);
    serve(1, 0, 2, 1'b0, 1'b0, 1'b0);
    dchk("bursts_early_end", begin_cnt - b0, 3);
    ci(8'd12, 3'd4, 1'b0, 32'd0, 1'b1, 32'd0);
    ci(8'd12, 3'd2, 1'b0, 32'd0, 1'b1, 32'd3);

    // bus error after 2 beats
    ci(8'd12, 3'd2, 1'b1, 32'd8, 1'b0, 32'd0);
    ci(8'd12, 3'd4, 1'b1, 32'd1, 1'b0, 32'd0);
    serve(1, 0, 2, 1'b0, 1'b1, 1'b0);
    step();
    ci(8'd12, 3'd4, 1'b0, 32'd0, 1'b1, 32'd2);
    ci(8'd12, 3'd5, 1'b0, 32'd0, 1'b1, CNT_ERR);

    // go with block 0: error cleared, no bus activity
    ci(8'd12, 3'd2, 1'b1, 32'd0, 1'b0, 32'd0);
    ci(8'd12, 3'd4, 1'b1, 32'd1, 1'b0, 32'd0);
    ci(8'd12, 3'd4, 1'b0, 32'd0, 1'b1, 32'd0);
    repeat (3) step();
    dchk("block0_no_request", int'(bus_request), 0);

    // restart: full 8-word transfer, then beat count
    ci(8'd12, 3'd2, 1'b1, 32'd8, 1'b0, 32'd0);
    ci(8'd12, 3'd4, 1'b1, 32'd1, 1'b0, 32'd0);
    serve(1, 0, 4, 1'b0, 1'b0, 1'b1);
    serve(1, 0, 4, 1'b0, 1'b0, 1'b0);
    ci(8'd12, 3'd4, 1'b0, 32'd0, 1'b1, 32'd0);
    ci(8'd12, 3'd5, 1'b0, 32'd0, 1'b1, CNT_FULL);

    // address registers and unused selects
    ci(8'd12, 3'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0);
    ci(8'd12, 3'd1, 1'b1, 32'h12345678, 1'b0, 32'd0);
    ci(8'd12, 3'd7, 1'b1, 32'hFFFFFFFF, 1'b0, 32'd0);
    ci(8'd12, 3'd0, 1'b0, 32'd0, 1'b1, 32'hDEADBEEF);
    ci(8'd12, 3'd1, 1'b0, 32'd0, 1'b1, 32'h12345678);
    ci(8'd12, 3'd7, 1'b0, 32'd0, 1'b1, 32'd0);
    ci(8'd12, 3'd6, 1'b0, 32'd0, 1'b1, 32'd0);

    repeat (3) step();
    dchk("ci_responses_pending", ci_q.size(), 0);
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_ctl_ci.md
Name: dma_ctl_ci

Overview:
- Custom-instruction (CI) programmed DMA transfer controller.
- The CPU writes and reads configuration/status registers through the CI interface. The block then runs a bus-master handshake FSM that moves a block of words as a sequence of bursts.
- Control-only: address/data datapath lives in the neighbouring bus-interface logic; this block sequences request/grant/begin/beat/end.

Parameters:
- customId, 8'd12, CI opcode this block responds to (ciN must equal it).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  CI start strobe.
- ciN  in  8  CI opcode.
- valueA  in  32  CI operand A: [12:10] register select, [9] write enable; other bits ignored.
- valueB  in  32  CI operand B: write data.
- result  out  32  CI read data.
- data_valid  out  1  CI done.
- bus_request  out  1  bus request to arbiter.
- bus_aquire  in  1  bus grant.
- begin_transaction  out  1  one-cycle burst start pulse.
- slave_busy  in  1  slave not ready; defers begin.
- in_valid  in  1  one data beat accepted this cycle.
- end_transaction  in  1  slave terminates current burst.
- bus_error  in  1  bus error.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM IDLE.
- CI accept: start && ciN==customId.
  - Writes take effect at the accept edge.
  - data_valid is a registered 1-cycle pulse on the next cycle.
  - result is valid with data_valid; otherwise result=0.
  - start with another ciN: ignored, no data_valid.
- Registers (select):
  - 0: bus start address, 32b.
  - 1: local start address, 32b.
  - 2: block size in words, 10b.
  - 3: burst size, 8b; burst length = value+1.
  - 4 write: control; bit0 = go, others ignored. Read: status {30'b0, error, busy}.
  - 5–7: read 0, writes ignored.
  - Reads of 0–3 return the stored value, zero-extended.
- Go handling:
  - Go while busy: ignored.
  - Go with block size 0: busy stays 0, error cleared, no bus activity.
  - Otherwise at the go edge: busy=1, error=0, remaining=block size, FSM to REQUEST.
- FSM states IDLE, REQUEST, BEGIN, TRANSFER, ERROR:
  - REQUEST: bus_request=1. Go to BEGIN the cycle after bus_aquire=1.
  - BEGIN: bus_request stays 1. If slave_busy=1, wait. Else assert begin_transaction for exactly one cycle, set beats=min(burst length, remaining), go to TRANSFER.
  - TRANSFER: bus_request=1. Each in_valid decrements beats and remaining.
    - Burst ends when beats reaches 0, or when end_transaction=1 (early termination; remaining reflects only counted beats).
    - in_valid and end_transaction in the same cycle: the beat counts, then the burst ends.
    - At burst end: remaining>0 → REQUEST (bus_request drops for one cycle); remaining=0 → IDLE, busy=0.
  - bus_error=1 in REQUEST/BEGIN/TRANSFER (precedence over all other events): go to ERROR. ERROR lasts one cycle with bus_request=0, sets error=1, then IDLE with busy=0.
- Reset asserted mid-transfer: immediate return to IDLE, all registers cleared.
- CI register writes during busy: take effect for the next go only. The current transfer uses values latched at go.
- Simultaneous CI status read and state change: the read returns the pre-edge value.

Optional Feature:
- Macro DMA_TRANSFER_COUNT_EN.
- Defined: register 5 read returns a 32b count of beats completed since the last go. It is cleared at go and by reset, and holds after completion or error.
- Undefined: register 5 reads 0, no counter logic.

Decomposition:
- Shared package dma_ctl_pkg:
  - FSM state enum.
  - Register select constants: REG_BUS_ADDR=0, REG_LOC_ADDR=1, REG_BLOCK=2, REG_BURST=3, REG_CTRL=4, REG_COUNT=5.
  - Field positions: SEL_MSB=12, SEL_LSB=10, WE_BIT=9.
- One natural sub-module: dma_ctl_regs (CI decode, register file, data_valid/result).
- FSM and counters stay in the top module.

Test Plan:
- Reset then read reg3 (valueA=0x00000C00) → data_valid pulse 1 cycle after start, result=0. Start with ciN=13 → no data_valid.
- Write reg3=3 (0xE00, valueB=3), reg2=8 (0xA00, valueB=8), go (0x1200, valueB=1). Grant after 2 cycles, slave_busy=0, 4 in_valid per burst → exactly two begin_transaction pulses, bus_request low 1 cycle between bursts. Status read (0x1000) gives 1 while running, 0 after.
- Block=5, burst reg=3 → bursts of 4 then 1 beat. slave_busy held 3 cycles in BEGIN delays begin_transaction by 3 cycles.
- Block=8, end_transaction after 2 beats in first burst → next burst length 4, total three bursts (2+4+2).
- bus_error pulse mid-TRANSFER → bus_request=0 next cycle, status reads 2. A new go clears error and restarts.
- Go with block=0 → no bus_request. Go while busy → ignored. With DMA_TRANSFER_COUNT_EN, reg5 read (0x1400) after an 8-word transfer returns 8.
